regfile_writer: RTL and testbench



---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_writer_wb_arbiter.sv | 81 ++++++++
 rtl/regfile_writer.sv | 107 ++++++++++
 tb/tb_regfile_writer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the integer register file, its write front end and
// the issue/hazard logic, plus the write-source select encoding.
package regfile_pkg;

   localparam int unsigned BIT        = 32;
   localparam int unsigned REG_NUM    = 32;
   localparam int unsigned ADDR_W     = $clog2(REG_NUM);
   localparam int unsigned STARVE_MAX = 4;

   // Which producer (if any) transfers on the current edge
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_ALU  = 2'd1,
      SRC_MEM  = 2'd2
   } src_e;

endpackage

// File: rtl/regfile_writer_wb_arbiter.sv
// wb_arbiter: picks one of the ALU / load results per cycle.
// Loads have priority. With REGFILE_WRITER_STARVE_EN defined, a counter of
// consecutive ALU denials forces one ALU win once it reaches STARVE_MAX.
// Readys depend only on the valids, the starvation state and rst.
module wb_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned STARVE_MAX = regfile_pkg::STARVE_MAX
) (
`ifdef REGFILE_WRITER_STARVE_EN
   input  logic clk,
`endif
   input  logic rst,
   input  logic alu_valid,
   input  logic mem_valid,
   output logic alu_ready,
   output logic mem_ready,
   output src_e sel
);

`ifdef REGFILE_WRITER_STARVE_EN
   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] starve_q;
   logic [CNT_W-1:0] starve_d;
   logic             force_alu;

   assign force_alu = (starve_q == CNT_W'(STARVE_MAX));

   // Ready generation: the forced cycle hands priority to the ALU
   always_comb begin
      alu_ready = 1'b0;
      mem_ready = 1'b0;
      if (!rst) begin
         if (force_alu) begin
            alu_ready = 1'b1;
            mem_ready = ~alu_valid;
         end else begin
            alu_ready = ~mem_valid;
            mem_ready = 1'b1;
         end
      end
   end

   // Count consecutive denials while both producers are offering
   always_comb begin
      starve_d = starve_q;
      if (!alu_valid || alu_ready) begin
         starve_d = '0;
      end else if (mem_valid) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // Starvation counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   // Strict load priority
   always_comb begin
      alu_ready = ~rst & ~mem_valid;
      mem_ready = ~rst;
   end
`endif

   // Select the producer whose handshake completes this cycle
   always_comb begin
      sel = SRC_NONE;
      if (mem_valid && mem_ready) begin
         sel = SRC_MEM;
      end else if (alu_valid && alu_ready) begin
         sel = SRC_ALU;
      end
   end

endmodule

// File: rtl/regfile_writer.sv
// regfile_writer: write-side front end of the integer register file.
// Accepts ALU and load results over valid/ready, drives the single register
// file write port from registers, and keeps the per-register busy scoreboard.
// Optional feature macro: REGFILE_WRITER_STARVE_EN (ALU anti-starvation).
module regfile_writer
   import regfile_pkg::*;
#(
   parameter  int unsigned BIT        = regfile_pkg::BIT,
   parameter  int unsigned REG_NUM    = regfile_pkg::REG_NUM,
   parameter  int unsigned STARVE_MAX = regfile_pkg::STARVE_MAX,
   localparam int unsigned ADDR_W     = $clog2(REG_NUM)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [BIT-1:0]    alu_data,
   output logic              alu_ready,
   input  logic              mem_valid,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic [BIT-1:0]    mem_data,
   output logic              mem_ready,
   input  logic              claim_valid,
   input  logic [ADDR_W-1:0] claim_rd,
   output logic [REG_NUM-1:0] busy,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [BIT-1:0]    wr_data
);

   src_e               sel;
   logic               wr_en_q,   wr_en_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [BIT-1:0]     wr_data_q, wr_data_d;
   logic [REG_NUM-1:0] busy_q,    busy_d;

   wb_arbiter #(
      .STARVE_MAX (STARVE_MAX)
   ) u_arb (
`ifdef REGFILE_WRITER_STARVE_EN
      .clk        (clk),
`endif
      .rst        (rst),
      .alu_valid  (alu_valid),
      .mem_valid  (mem_valid),
      .alu_ready  (alu_ready),
      .mem_ready  (mem_ready),
      .sel        (sel)
   );

   // Write port next state; transfers to x0 are consumed without a write
   always_comb begin
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      case (sel)
         SRC_MEM: begin
            if (mem_rd != '0) begin
               wr_en_d   = 1'b1;
               wr_addr_d = mem_rd;
               wr_data_d = mem_data;
            end
         end
         SRC_ALU: begin
            if (alu_rd != '0) begin
               wr_en_d   = 1'b1;
               wr_addr_d = alu_rd;
               wr_data_d = alu_data;
            end
         end
         default: ;
      endcase
   end

   // Scoreboard next state: clear on commit, then claim so a same-edge claim wins
   always_comb begin
      busy_d = busy_q;
      if (wr_en_q) begin
         busy_d[wr_addr_q] = 1'b0;
      end
      if (claim_valid) begin
         busy_d[claim_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Output and scoreboard registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= '0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_regfile_writer.sv
// Directed bench for regfile_writer with hand-computed expectations.
// Honours REGFILE_WRITER_STARVE_EN for the starvation scenario.
module tb_regfile_writer;

   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        mem_valid;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        mem_ready;
   logic        claim_valid;
   logic [4:0]  claim_rd;
   logic [31:0] busy;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   int unsigned n_cmp;
   int unsigned n_err;

   regfile_writer #(
      .BIT        (32),
      .REG_NUM    (32),
      .STARVE_MAX (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .alu_ready   (alu_ready),
      .mem_valid   (mem_valid),
      .mem_rd      (mem_rd),
      .mem_data    (mem_data),
      .mem_ready   (mem_ready),
      .claim_valid (claim_valid),
      .claim_rd    (claim_rd),
      .busy        (busy),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      rst         = 1'b0;
      alu_valid   = 1'b0;
      alu_rd      = '0;
      alu_data    = '0;
      mem_valid   = 1'b0;
      mem_rd      = '0;
      mem_data    = '0;
      claim_valid = 1'b0;
      claim_rd    = '0;

      // Reset: readys low even with both valids offered
      #1 rst = 1'b1;
      alu_valid = 1'b1;
      mem_valid = 1'b1;
      #1;
      chk("rst_alu_ready", 64'(alu_ready), 64'd0);
      chk("rst_mem_ready", 64'(mem_ready), 64'd0);
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_wr_en",   64'(wr_en),   64'd0);
      chk("rst_wr_addr", 64'(wr_addr), 64'd0);
      chk("rst_wr_data", 64'(wr_data), 64'd0);
      chk("rst_busy",    64'(busy),    64'd0);

      // Single ALU write to x5
      claim_valid = 1'b1; claim_rd = 5'd5;
      tick();
      claim_valid = 1'b0;
      chk("t1_busy_claim", 64'(busy), 64'h20);
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      #1;
      chk("t1_alu_ready", 64'(alu_ready), 64'd1);
      chk("t1_mem_ready", 64'(mem_ready), 64'd1);
      tick();
      alu_valid = 1'b0;
      chk("t1_wr_en",   64'(wr_en),   64'd1);
      chk("t1_wr_addr", 64'(wr_addr), 64'd5);
      chk("t1_wr_data", 64'(wr_data), 64'hDEADBEEF);
      chk("t1_busy_inflight", 64'(busy), 64'h20);
      tick();
      chk("t1_wr_en_off", 64'(wr_en),   64'd0);
      chk("t1_addr_hold", 64'(wr_addr), 64'd5);
      chk("t1_data_hold", 64'(wr_data), 64'hDEADBEEF);
      chk("t1_busy_clr",  64'(busy),    64'd0);

      // Collision: load to x3 wins, ALU to x4 follows
      claim_valid = 1'b1; claim_rd = 5'd3;
      tick();
      claim_rd = 5'd4;
      tick();
      claim_valid = 1'b0;
      chk("t2_busy_claim", 64'(busy), 64'h18);
      mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
      #1;
      chk("t2_mem_ready", 64'(mem_ready), 64'd1);
      chk("t2_alu_ready", 64'(alu_ready), 64'd0);
      tick();
      mem_valid = 1'b0;
      chk("t2_w1_en",   64'(wr_en),   64'd1);
      chk("t2_w1_addr", 64'(wr_addr), 64'd3);
      chk("t2_w1_data", 64'(wr_data), 64'h11);
      #1;
      chk("t2_alu_ready2", 64'(alu_ready), 64'd1);
      tick();
      alu_valid = 1'b0;
      chk("t2_w2_en",   64'(wr_en),   64'd1);
      chk("t2_w2_addr", 64'(wr_addr), 64'd4);
      chk("t2_w2_data", 64'(wr_data), 64'h22);
      chk("t2_busy_mid", 64'(busy), 64'h10);
      tick();
      chk("t2_idle_en", 64'(wr_en), 64'd0);
      chk("t2_busy_end", 64'(busy), 64'd0);

      // Register 0: claim ignored, result consumed without a write
      claim_valid = 1'b1; claim_rd = 5'd0;
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
      #1;
      chk("t3_alu_ready", 64'(alu_ready), 64'd1);
      tick();
      claim_valid = 1'b0;
      alu_valid = 1'b0;
      chk("t3_wr_en", 64'(wr_en), 64'd0);
      chk("t3_busy",  64'(busy),  64'd0);
      tick();
      chk("t3_wr_en2", 64'(wr_en), 64'd0);
      chk("t3_busy2",  64'(busy),  64'd0);

      // Claim/clear race on x7: claim wins at the commit edge
      claim_valid = 1'b1; claim_rd = 5'd7;
      tick();
      claim_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
      tick();
      alu_valid = 1'b0;
      chk("t4_wr_en",   64'(wr_en),   64'd1);
      chk("t4_wr_addr", 64'(wr_addr), 64'd7);
      claim_valid = 1'b1; claim_rd = 5'd7;
      tick();
      claim_valid = 1'b0;
      chk("t4_busy_kept", 64'(busy), 64'h80);
      chk("t4_wr_en_off", 64'(wr_en), 64'd0);

      // Starvation: loads stream to x10 while the ALU offers x9
      mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hA0;
      alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h99;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("t5_deny%0d_alu", i), 64'(alu_ready), 64'd0);
         chk($sformatf("t5_deny%0d_mem", i), 64'(mem_ready), 64'd1);
         tick();
         chk($sformatf("t5_deny%0d_addr", i), 64'(wr_addr), 64'd10);
      end
`ifdef REGFILE_WRITER_STARVE_EN
      #1;
      chk("t5_force_alu", 64'(alu_ready), 64'd1);
      chk("t5_force_mem", 64'(mem_ready), 64'd0);
      tick();
      chk("t5_alu_wr_en",   64'(wr_en),   64'd1);
      chk("t5_alu_wr_addr", 64'(wr_addr), 64'd9);
      chk("t5_alu_wr_data", 64'(wr_data), 64'h99);
      // Counter restarted: next ALU offer is denied again
      alu_rd = 5'd12; alu_data = 32'hC0;
      #1;
      chk("t5_after_alu", 64'(alu_ready), 64'd0);
      chk("t5_after_mem", 64'(mem_ready), 64'd1);
`else
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("t5_nostarve%0d_alu", i), 64'(alu_ready), 64'd0);
         tick();
         chk($sformatf("t5_nostarve%0d_addr", i), 64'(wr_addr), 64'd10);
      end
`endif
      mem_valid = 1'b0;
      alu_valid = 1'b0;
      tick();

      // Reset mid-write with busy = 0xF00
      rst = 1'b1;
      #1 rst = 1'b0;
      tick();
      for (int r = 8; r < 11; r++) begin
         claim_valid = 1'b1; claim_rd = 5'(r);
         tick();
      end
      claim_rd = 5'd11;
      alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hBB;
      tick();
      claim_valid = 1'b0;
      mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 32'h88;
      chk("t6_pre_wr_en", 64'(wr_en), 64'd1);
      chk("t6_pre_busy",  64'(busy),  64'hF00);
      #1 rst = 1'b1;
      #1;
      chk("t6_wr_en",     64'(wr_en),     64'd0);
      chk("t6_busy",      64'(busy),      64'd0);
      chk("t6_wr_addr",   64'(wr_addr),   64'd0);
      chk("t6_wr_data",   64'(wr_data),   64'd0);
      chk("t6_alu_ready", 64'(alu_ready), 64'd0);
      chk("t6_mem_ready", 64'(mem_ready), 64'd0);
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
